// File: rtl/qsort_pkg.sv
// qsort_pkg: shared state encoding and sorter address defaults for qsort_dma.
package qsort_pkg;
    typedef enum logic [2:0] {
        IDLE, RD_SRC, WAIT_RDY, WR_SORT, WAIT_DONE, RD_SORT, WR_DST, FIN
    } state_e;
    localparam int          DEF_SIZE         = 10;
    localparam logic [31:0] DEF_SORT_WR_ADDR = 32'h3810_0000;
    localparam logic [31:0] DEF_SORT_RD_ADDR = 32'h3810_0010;
endpackage

// File: rtl/wb_master_beat.sv
// wb_master_beat: single-beat classic Wishbone master; launches on req when idle,
// holds cyc/stb until ack (or abort), so stb is always low for >=1 cycle between beats.
module wb_master_beat (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] wdat_i,
    input  logic        abort_i,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [31:0] rdat_o,
    output logic        done_o
);
    logic        stb_q, we_q;
    logic [31:0] adr_q, dat_q, rdat_q;

    assign cyc_o  = stb_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
    assign rdat_o = rdat_q;
    assign done_o = stb_q & ack_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            rdat_q <= '0;
        end else if (stb_q) begin
            if (ack_i || abort_i) stb_q <= 1'b0;
            if (ack_i && !we_q) rdat_q <= dat_i;
        end else if (req_i) begin
            stb_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= wdat_i;
        end
    end
endmodule

// File: rtl/qsort_dma.sv
// qsort_dma: Wishbone DMA feeding SIZE source words into the sorter and draining the
// sorted result to a destination region. QSORT_DMA_TIMEOUT_EN adds an ack/wait watchdog.
module qsort_dma
    import qsort_pkg::*;
#(
    parameter int          SIZE         = DEF_SIZE,
    parameter logic [31:0] SORT_WR_ADDR = DEF_SORT_WR_ADDR,
    parameter logic [31:0] SORT_RD_ADDR = DEF_SORT_RD_ADDR
`ifdef QSORT_DMA_TIMEOUT_EN
    , parameter int        TIMEOUT_CYC  = 1024
`endif
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [31:0] src_base_i,
    input  logic [31:0] dst_base_i,
    input  logic        sorter_ready_i,
    input  logic        sorter_done_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        irq_o,
    output logic        err_o
);
    localparam int IW = $clog2(SIZE);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     src_q, dst_q, off, adr, rdat;
    logic            done_q, req, we, bdone, last, accept, tmo_hit;

    assign off     = {{(30-IW){1'b0}}, idx_q, 2'b00};
    assign last    = idx_q == IW'(SIZE-1);
    assign accept  = (state_q == IDLE) && start_i;
    assign m_sel_o = 4'hF;
    assign busy_o  = state_q != IDLE;
    assign done_o  = done_q;
    assign irq_o   = (state_q == FIN) || tmo_hit;

    wb_master_beat u_beat (
        .clk_i(wb_clk_i), .rst_n_i(wb_rst_n_i), .req_i(req), .we_i(we), .adr_i(adr),
        .wdat_i(rdat), .abort_i(tmo_hit), .ack_i(m_ack_i), .dat_i(m_dat_i),
        .cyc_o(m_cyc_o), .stb_o(m_stb_o), .we_o(m_we_o), .adr_o(m_adr_o),
        .dat_o(m_dat_o), .rdat_o(rdat), .done_o(bdone)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        req     = 1'b0;
        we      = 1'b0;
        adr     = '0;
        case (state_q)
            IDLE:      if (start_i) begin state_d = RD_SRC; idx_d = '0; end
            RD_SRC:    begin req = 1'b1; adr = src_q + off; if (bdone) state_d = WAIT_RDY; end
            WAIT_RDY:  if (sorter_ready_i) state_d = WR_SORT;
            WR_SORT: begin
                req = 1'b1;
                we  = 1'b1;
                adr = SORT_WR_ADDR;
                if (bdone) begin
                    state_d = last ? WAIT_DONE : RD_SRC;
                    idx_d   = last ? '0 : idx_q + 1'b1;
                end
            end
            WAIT_DONE: if (sorter_done_i) state_d = RD_SORT;
            RD_SORT:   begin req = 1'b1; adr = SORT_RD_ADDR; if (bdone) state_d = WR_DST; end
            WR_DST: begin
                req = 1'b1;
                we  = 1'b1;
                adr = dst_q + off;
                if (bdone) begin
                    state_d = last ? FIN : RD_SORT;
                    idx_d   = last ? idx_q : idx_q + 1'b1;
                end
            end
            FIN:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                src_q  <= src_base_i;
                dst_q  <= dst_base_i;
                done_q <= 1'b0;
            end else if (state_q == FIN) begin
                done_q <= 1'b1;
            end
        end
    end

`ifdef QSORT_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q, counting;

    // Counts stalled strobes and both sorter waits; any state change restarts it.
    assign counting = (m_stb_o && !m_ack_i) || state_q == WAIT_RDY || state_q == WAIT_DONE;
    assign tmo_hit  = counting && tmo_q == TW'(TIMEOUT_CYC - 1);
    assign err_o    = err_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_d != state_q) ? '0 : counting ? tmo_q + 1'b1 : tmo_q;
            err_q <= accept ? 1'b0 : tmo_hit ? 1'b1 : err_q;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_qsort_dma.sv
// tb_qsort_dma: random-latency Wishbone slave, sorter model and destination scoreboard.
module tb_qsort_dma;
    localparam int          N    = 10;
    localparam logic [31:0] WR_A = 32'h3810_0000;
    localparam logic [31:0] RD_A = 32'h3810_0010;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 0, rst_n = 0, start = 0, rdy = 1, sdone = 0, ack = 0;
    logic [31:0] src_b = 0, dst_b = 0, rdata = 0;
    logic        m_cyc, m_stb, m_we, busy, done, irq, err;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;

    exp_t        exp_q[$];
    logic [31:0] sort_q[$];
    logic [31:0] mem[logic [31:0]];
    int compared = 0, mismatched = 0, nwr = 0, nrd = 0, irq_cnt = 0, lat_max = 0, rdy_delay = 0;

    qsort_dma dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .src_base_i(src_b),
        .dst_base_i(dst_b), .sorter_ready_i(rdy), .sorter_done_i(sdone),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(rdata), .m_ack_i(ack),
        .busy_o(busy), .done_o(done), .irq_o(irq), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail(input string msg);
        compared++;
        mismatched++;
        $display("FAIL %s", msg);
    endtask

    // Wishbone slave + sorter model + scoreboard monitor on destination writes
    initial begin
        int   lat;
        bit   armed;
        int   rdy_lo;
        exp_t e;
        lat = 0; armed = 0; rdy_lo = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 0; armed = 0; rdy_lo = 0; rdy = 1;
            end else begin
                if (rdy_lo > 0) rdy_lo--;
                rdy = (rdy_lo == 0);
                if (ack) begin
                    ack = 0;
                    check("stb low after ack", 32'(m_stb), 32'd0);
                end else if (m_stb) begin
                    if (!armed) begin
                        armed = 1;
                        lat = $urandom_range(lat_max, 0);
                        check("cyc equals stb", 32'(m_cyc), 32'(m_stb));
                        check("sel", 32'(m_sel), 32'hF);
                        if (m_we && m_adr == WR_A) check("ready at sorter write", 32'(rdy), 32'd1);
                    end
                    if (lat > 0) lat--;
                    else begin
                        armed = 0;
                        ack = 1;
                        if (m_we) begin
                            if (m_adr == WR_A) begin
                                sort_q.push_back(m_dat);
                                nwr++;
                                rdy_lo = rdy_delay;
                                rdy = (rdy_lo == 0);
                                sdone = (nwr == N);
                            end else if (exp_q.size() == 0) begin
                                fail($sformatf("dst write: got adr %h, required no write", m_adr));
                            end else begin
                                e = exp_q.pop_front();
                                check("dst addr", m_adr, e.a);
                                check("dst data", m_dat, e.d);
                            end
                        end else if (m_adr == RD_A) begin
                            nrd++;
                            if (sort_q.size() == 0) fail("sorter read: got empty sorter, required data");
                            else begin
                                sort_q.sort();
                                rdata = sort_q.pop_front();
                            end
                        end else begin
                            compared++;
                            if (mem.exists(m_adr)) rdata = mem[m_adr];
                            else begin
                                mismatched++;
                                $display("FAIL src read addr: got %h, required a source word address", m_adr);
                            end
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (irq) irq_cnt++;
    end

    task automatic prep(input logic [31:0] s, input logic [31:0] d, input logic [31:0] v[N],
                        input int lm, input int rd);
        logic [31:0] sorted[$];
        lat_max = lm; rdy_delay = rd; nwr = 0; nrd = 0; irq_cnt = 0; sdone = 0;
        sort_q.delete(); exp_q.delete(); mem.delete();
        for (int k = 0; k < N; k++) begin
            mem[s + 32'(4*k)] = v[k];
            sorted.push_back(v[k]);
        end
        sorted.sort();
        for (int k = 0; k < N; k++) exp_q.push_back('{d + 32'(4*k), sorted[k]});
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] v[N],
                           input int lm, input int rd, input int restart_at);
        int c;
        prep(s, d, v, lm, rd);
        @(negedge clk);
        src_b = s; dst_b = d; start = 1;
        @(negedge clk);
        start = 0;
        check("busy after start", 32'(busy), 32'd1);
        check("done cleared on start", 32'(done), 32'd0);
        c = 0;
        while (!done && c < 5000) begin
            @(negedge clk);
            c++;
            if (c == restart_at) begin
                src_b = 32'h2000_0000; dst_b = 32'h5000_0000; start = 1;
            end else start = 0;
        end
        start = 0;
        if (!done) fail("job end: got done_o=0, required 1");
        repeat (3) @(negedge clk);
        check("irq pulses", 32'(irq_cnt), 32'd1);
        check("sorter writes", 32'(nwr), 32'(N));
        check("sorter reads", 32'(nrd), 32'(N));
        check("dst writes left", 32'(exp_q.size()), 32'd0);
        check("busy at end", 32'(busy), 32'd0);
        check("done at end", 32'(done), 32'd1);
        check("err at end", 32'(err), 32'd0);
    endtask

    task automatic reset_mid();
        logic [31:0] v[N];
        int c;
        for (int k = 0; k < N; k++) v[k] = $urandom;
        prep(32'h0000_0100, 32'h0000_0800, v, 3, 1);
        @(negedge clk);
        src_b = 32'h0000_0100; dst_b = 32'h0000_0800; start = 1;
        @(negedge clk);
        start = 0;
        c = 0;
        while (!(m_stb && m_we && m_adr == WR_A && nwr == 3) && c < 5000) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (c >= 5000) fail("reset point: got no 4th sorter write, required one");
        #1 rst_n = 0;
        #1;
        check("cyc after async reset", 32'(m_cyc), 32'd0);
        check("stb after async reset", 32'(m_stb), 32'd0);
        check("busy after async reset", 32'(busy), 32'd0);
        check("done after async reset", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] v[N];
        logic [31:0] s, d;
        rst_n = 0;
        #12;
        check("reset cyc", 32'(m_cyc), 32'd0);
        check("reset stb", 32'(m_stb), 32'd0);
        check("reset we", 32'(m_we), 32'd0);
        check("reset adr", m_adr, 32'd0);
        check("reset dat", m_dat, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1;
        v = '{893, 40, 3233, 4267, 2669, 2541, 9073, 6023, 5681, 4622};
        run_job(32'h0000_1000, 32'h0000_2000, v, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) v[k] = $urandom;
            s = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
            d = 32'h6000_0000 | ($urandom & 32'h0FFF_FFFC);
            run_job(s, d, v, 5, 3, 0);
        end
        for (int k = 0; k < N; k++) v[k] = $urandom_range(9999, 0);
        run_job(32'h0000_4000, 32'h0000_8000, v, 2, 1, 40);
        reset_mid();
        for (int k = 0; k < N; k++) v[k] = $urandom;
        run_job(32'h0000_0300, 32'h0000_0900, v, 4, 3, 0);
        for (int k = 0; k < N; k++) v[k] = $urandom;
        run_job(32'hFFFF_FFF8, 32'hFFFF_FFF0, v, 1, 2, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
